// File: rtl/data_ram_pipelined_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_ram_pipelined_if : access/clear bus between the MEM stage and the RAM |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface data_ram_pipelined_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wmask;
  logic                  clear_req;
  logic                  ready;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;
  logic                  err;
  logic                  clr_busy;

  modport master (
    output req, we, addr, wdata, wmask, clear_req,
    input  ready, rvalid, rdata, err, clr_busy
  );

  modport slave (
    input  req, we, addr, wdata, wmask, clear_req,
    output ready, rvalid, rdata, err, clr_busy
  );
endinterface
`default_nettype wire

// File: rtl/data_ram_pipelined.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_ram_pipelined : single-port RAM, registered read, byte-masked writes, |
// | range check and clear sweeper.                          Revision 1.0       |
// +----------------------------------------------------------------------------+
module data_ram_pipelined #(
  parameter int               DATA_W         = 16,
  parameter int               ADDR_W         = 16,
  parameter int               DEPTH          = 256,
  parameter int               CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE   = '0
) (
  input  wire logic              clk,
  input  wire logic              reset,
  data_ram_pipelined_if.slave    bus
);

  localparam int                 c_LANES = DATA_W / 8;
  localparam int                 c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]    c_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam state_t c_RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  state_t               r_state;
  logic [c_IDX_W-1:0]   r_clr_ptr;
  logic                 r_rvalid;
  logic                 r_err;
  logic [DATA_W-1:0]    r_rdata;
  logic [DATA_W-1:0]    r_mem [DEPTH];

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_in_range;
  logic                 w_clr_we;
  logic [c_IDX_W-1:0]   w_idx;

  // Clear request pre-empts an access in the same cycle, so ready drops combinationally.
  assign w_ready    = (r_state == S_IDLE) && !bus.clear_req;
  assign w_accept   = bus.req && w_ready;
  assign w_in_range = ({1'b0, bus.addr} < c_DEPTH);
  assign w_idx      = bus.addr[c_IDX_W-1:0];
  assign w_clr_we   = (r_state == S_CLEAR) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= c_RESET_STATE;
      r_clr_ptr <= '0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.clear_req) begin
            r_state <= S_CLEAR;
          end else if (w_accept) begin
            r_err <= !w_in_range;
            if (!bus.we) begin
              r_rvalid <= 1'b1;
              r_rdata  <= w_in_range ? r_mem[w_idx] : '0;
            end
          end
        end
        S_CLEAR: begin
          if (r_clr_ptr == c_LAST) begin
            r_clr_ptr <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Array has no reset; out-of-range writes never reach it, so nothing aliases.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_ptr] <= CLEAR_VALUE;
    end else if (w_accept && bus.we && w_in_range) begin
      for (int i = 0; i < c_LANES; i++) begin
        if (bus.wmask[i]) begin
          r_mem[w_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.ready    = w_ready;
  assign bus.rvalid   = r_rvalid;
  assign bus.rdata    = r_rdata;
  assign bus.err      = r_err;
  assign bus.clr_busy = (r_state == S_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_data_ram_pipelined.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_data_ram_pipelined : directed bench for data_ram_pipelined (DEPTH=256)  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_data_ram_pipelined;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  data_ram_pipelined_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  data_ram_pipelined #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(256), .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] m);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    bus.wmask = m;
    tick;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
  endtask

  // Counts negedges with clr_busy high; flags any ready/rvalid/err seen meanwhile.
  task automatic sweep_len(output int n, output logic bad);
    n   = 0;
    bad = 1'b0;
    while (bus.clr_busy === 1'b1 && n < 1000) begin
      if (bus.ready !== 1'b0 || bus.rvalid !== 1'b0 || bus.err !== 1'b0) bad = 1'b1;
      n++;
      tick;
    end
  endtask

  int   len;
  logic bad;

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.wmask = '0; bus.clear_req = 1'b0;

    // reset state
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_ready",    bus.ready,    0);
    chk("rst_clr_busy", bus.clr_busy, 1);
    chk("rst_rvalid",   bus.rvalid,   0);
    chk("rst_err",      bus.err,      0);
    chk("rst_rdata",    bus.rdata,    0);
    tick;
    reset = 1'b0;

    // post-reset sweep length
    sweep_len(len, bad);
    chk("sweep1_len",  len, 256);
    chk("sweep1_quiet", bad, 0);
    chk("idle_ready",  bus.ready, 1);

    access(1'b0, 16'h00FF, 16'h0, 2'b00);
    chk("rd_ff_rvalid", bus.rvalid, 1);
    chk("rd_ff_rdata",  bus.rdata,  16'h0000);
    chk("rd_ff_err",    bus.err,    0);
    tick;
    chk("rvalid_pulse", bus.rvalid, 0);

    // full write then read-after-write
    access(1'b1, 16'h0010, 16'hBEEF, 2'b11);
    chk("wr_rvalid", bus.rvalid, 0);
    chk("wr_err",    bus.err,    0);
    access(1'b0, 16'h0010, 16'h0, 2'b00);
    chk("raw_rvalid", bus.rvalid, 1);
    chk("raw_rdata",  bus.rdata,  16'hBEEF);

    // byte lanes
    access(1'b1, 16'h0010, 16'h12AB, 2'b01);
    access(1'b0, 16'h0010, 16'h0, 2'b00);
    chk("lane0_rdata", bus.rdata, 16'hBEAB);
    access(1'b1, 16'h0010, 16'h34CD, 2'b10);
    access(1'b1, 16'h0010, 16'hFFFF, 2'b00);
    access(1'b0, 16'h0010, 16'h0, 2'b00);
    chk("lane1_nop_rdata", bus.rdata, 16'h34AB);

    // back-to-back reads
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0010;
    tick;
    chk("b2b1_rdata", bus.rdata, 16'h34AB);
    chk("b2b1_rvalid", bus.rvalid, 1);
    bus.addr = 16'h00FF;
    tick;
    bus.req = 1'b0;
    chk("b2b2_rdata", bus.rdata, 16'h0000);
    chk("b2b2_rvalid", bus.rvalid, 1);

    // out of range
    access(1'b0, 16'h0010, 16'h0, 2'b00);
    access(1'b0, 16'h0100, 16'h0, 2'b00);
    chk("oor_rd_rdata",  bus.rdata,  16'h0000);
    chk("oor_rd_rvalid", bus.rvalid, 1);
    chk("oor_rd_err",    bus.err,    1);
    access(1'b1, 16'h0100, 16'h5555, 2'b11);
    chk("oor_wr_err",    bus.err,    1);
    chk("oor_wr_rvalid", bus.rvalid, 0);
    tick;
    chk("err_pulse", bus.err, 0);
    access(1'b0, 16'h0000, 16'h0, 2'b00);
    chk("oor_noalias", bus.rdata, 16'h0000);
    access(1'b0, 16'h0010, 16'h0, 2'b00);
    chk("oor_keep10", bus.rdata, 16'h34AB);

    // clear wins over a simultaneous request
    bus.clear_req = 1'b1; bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0010;
    #1 chk("clr_req_ready", bus.ready, 0);
    tick;
    bus.clear_req = 1'b0;
    sweep_len(len, bad);
    chk("sweep2_len",   len, 256);
    chk("sweep2_quiet", bad, 0);
    chk("held_ready",   bus.ready, 1);
    tick;
    bus.req = 1'b0;
    chk("held_rvalid", bus.rvalid, 1);
    chk("held_rdata",  bus.rdata,  16'h0000);

    // reset in the middle of a sweep restarts it
    access(1'b1, 16'h00FF, 16'h1234, 2'b11);
    bus.clear_req = 1'b1;
    tick;
    bus.clear_req = 1'b0;
    repeat (100) tick;
    reset = 1'b1;
    #1;
    chk("rst_mid_busy",   bus.clr_busy, 1);
    chk("rst_mid_rvalid", bus.rvalid,   0);
    tick;
    tick;
    reset = 1'b0;
    sweep_len(len, bad);
    chk("sweep3_len",   len, 256);
    chk("sweep3_quiet", bad, 0);
    access(1'b0, 16'h00FF, 16'h0, 2'b00);
    chk("sweep3_ff", bus.rdata, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
